// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared constants and counter sizing for the key panel.
package key_pkg;

  localparam int MODE_TOGGLE    = 0;
  localparam int MODE_MOMENTARY = 1;

  // Bits needed to hold the values 0..max_count inclusive.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key channel: 2-flop sync, stability counter,
// debounced level (1 = released) and one-cycle press/release pulses.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int              CW       = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0]   DEB_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DEB_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Everything resets to "released" so a key held through reset must re-qualify.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= key_raw_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = level_dly_q & ~level_q;
  assign release_o = ~level_dly_q & level_q;

endmodule

// File: rtl/key_panel_ctrl.sv
// rtl/key_panel_ctrl.sv - enable-gated key flags, LED drive, captured
// sequence word with change strobe, and per-key long-press pulses.
module key_panel_ctrl
  import key_pkg::*;
#(
  parameter int KEY_NUM     = 3,
  parameter int DEB_CYCLES  = 1000000,
  parameter int LONG_CYCLES = 50000000,
  parameter int MODE        = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_en,
  input  logic [KEY_NUM-1:0] key_in,
  output logic               en_led,
  output logic [KEY_NUM-1:0] key_led,
  output logic [KEY_NUM-1:0] seq_data,
  output logic               seq_valid,
  output logic [KEY_NUM-1:0] long_press
);

  localparam int            LW        = cnt_width(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

  // Channel 0 is the enable key, channels 1..KEY_NUM are the data keys.
  logic [KEY_NUM:0] raw_all, lvl_all, prs_all, rel_all;
  assign raw_all = {key_in, key_en};

  for (genvar g = 0; g <= KEY_NUM; g++) begin : g_deb
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_raw_i (raw_all[g]),
      .level_o   (lvl_all[g]),
      .press_o   (prs_all[g]),
      .release_o (rel_all[g])
    );
  end

  logic [KEY_NUM+1:0] unused_sigs;
  assign unused_sigs = {lvl_all[0], rel_all};

  logic [KEY_NUM-1:0] key_level, key_press;
  assign key_level = lvl_all[KEY_NUM:1];
  assign key_press = prs_all[KEY_NUM:1];

  logic               en_flag_q, en_flag_d, en_led_q;
  logic [KEY_NUM-1:0] flag_q, flag_d, key_led_q;
  logic [KEY_NUM-1:0] seq_data_q, seq_data_d;
  logic               seq_valid_q, seq_valid_d;
  logic [KEY_NUM-1:0] long_q, long_d;
  logic [LW-1:0]      hold_q [KEY_NUM];
  logic [LW-1:0]      hold_d [KEY_NUM];

  // Data flags look at the old enable flag, so a same-cycle enable press
  // either drops the data press or lets it toggle for one cycle.
  always_comb begin
    en_flag_d = en_flag_q ^ prs_all[0];
    if (!en_flag_q) begin
      flag_d = '0;
    end else if (MODE == MODE_TOGGLE) begin
      flag_d = flag_q ^ key_press;
    end else begin
      flag_d = ~key_level;
    end

    seq_data_d  = en_flag_q ? key_led_q : seq_data_q;
    seq_valid_d = en_flag_q && (key_led_q != seq_data_q);

    for (int k = 0; k < KEY_NUM; k++) begin
      if (key_level[k]) begin
        hold_d[k] = '0;
      end else if (hold_q[k] != LONG_MAX) begin
        hold_d[k] = hold_q[k] + 1'b1;
      end else begin
        hold_d[k] = hold_q[k];
      end
      long_d[k] = !key_level[k] && (hold_q[k] == LONG_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_flag_q   <= 1'b0;
      en_led_q    <= 1'b0;
      flag_q      <= '0;
      key_led_q   <= '0;
      seq_data_q  <= '0;
      seq_valid_q <= 1'b0;
      long_q      <= '0;
      for (int k = 0; k < KEY_NUM; k++) hold_q[k] <= '0;
    end else begin
      en_flag_q   <= en_flag_d;
      en_led_q    <= en_flag_q;
      flag_q      <= flag_d;
      key_led_q   <= flag_q;
      seq_data_q  <= seq_data_d;
      seq_valid_q <= seq_valid_d;
      long_q      <= long_d;
      for (int k = 0; k < KEY_NUM; k++) hold_q[k] <= hold_d[k];
    end
  end

  assign en_led     = en_led_q;
  assign key_led    = key_led_q;
  assign seq_data   = seq_data_q;
  assign seq_valid  = seq_valid_q;
  assign long_press = long_q;

endmodule
